// File: rtl/swd_pkg.sv
// Shared definitions for the SWD target port: ACK encodings, protocol state
// encoding, bit positions of the request fields after the start bit, and
// the even-parity helper used on both request and data phases.
package swd_pkg;

  typedef logic [2:0] ack_t;

  localparam ack_t ACK_OK    = 3'b001;
  localparam ack_t ACK_WAIT  = 3'b010;
  localparam ack_t ACK_FAULT = 3'b100;

  typedef enum logic [3:0] {
    ST_LOCKOUT,
    ST_LRST,
    ST_IDLE,
    ST_REQ,
    ST_TRN1,
    ST_ACK,
    ST_RDATA,
    ST_TRN2,
    ST_WDATA
  } swd_state_e;

  // Request bit index counted from the first bit after the start bit.
  // The first four also index the captured field register.
  localparam int REQ_APNDP = 0;
  localparam int REQ_RNW   = 1;
  localparam int REQ_A2    = 2;
  localparam int REQ_A3    = 3;
  localparam int REQ_PAR   = 4;
  localparam int REQ_STOP  = 5;
  localparam int REQ_PARK  = 6;

  // 1 when d has an odd number of ones, making the total even.
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/swd_target_port_if.sv
// Back-end handshake between the SWD target port and the DP/AP register
// block. master = protocol engine, slave = register back end.
//   req_*        decoded request, req_valid is a one-CLK pulse
//   rsp_*        level response sampled at the turnaround rise
//   wr_*         write data delivery and parity error pulse
interface swd_target_port_if;
  import swd_pkg::*;

  logic        req_valid;
  logic        req_apndp;
  logic        req_rnw;
  logic [1:0]  req_addr;
  logic        rsp_valid;
  ack_t        rsp_ack;
  logic [31:0] rsp_rdata;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_parity_err;

  modport master (
    output req_valid, req_apndp, req_rnw, req_addr,
    output wr_valid, wr_data, wr_parity_err,
    input  rsp_valid, rsp_ack, rsp_rdata
  );

  modport slave (
    input  req_valid, req_apndp, req_rnw, req_addr,
    input  wr_valid, wr_data, wr_parity_err,
    output rsp_valid, rsp_ack, rsp_rdata
  );
endinterface

// File: rtl/swd_sync_edge.sv
// Synchronises the asynchronous SWCLK and SWDIO pad inputs into the system
// clock domain and produces a one-CLK pulse on each synchronised SWCLK rise.
//   clk_i, rst_i   system clock, synchronous active-high reset
//   swclk_i        raw SWCLK
//   swdio_i        raw SWDIO pad input
//   rise_o         one-CLK pulse on synced SWCLK 0->1
//   swdio_o        synced SWDIO, valid to sample while rise_o is high
module swd_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic swclk_i,
  input  logic swdio_i,
  output logic rise_o,
  output logic swdio_o
);
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dio_sync_q;
  logic                   clk_prev_q;

  // SWDIO goes through the same depth as SWCLK so the data bit seen with
  // the rise pulse is the one present at the pad edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q <= '0;
      dio_sync_q <= '0;
      clk_prev_q <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], swclk_i};
      dio_sync_q <= {dio_sync_q[SYNC_STAGES-2:0], swdio_i};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o  = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
  assign swdio_o = dio_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/swd_target_port.sv
// SWD target-side protocol engine. Oversamples SWCLK/SWDIO on CLK, decodes
// line reset, request, turnaround, ACK and data phases, and hands DP/AP
// accesses to a register back end.
//   CLK, PORESET        system clock, synchronous active-high reset
//   SWCLK, SWDIO_I      asynchronous SWD pins from the host
//   SWDIO_O, SWDIO_OE   registered pad drive, update 1 CLK after a rise
//   be                  back-end request/response/write interface
//   line_reset          pulse when LINE_RESET_BITS consecutive 1s are seen
//   protocol_err        pulse on a malformed request
module swd_target_port
  import swd_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int LINE_RESET_BITS = 50
) (
  input  logic                     CLK,
  input  logic                     PORESET,
  input  logic                     SWCLK,
  input  logic                     SWDIO_I,
  output logic                     SWDIO_O,
  output logic                     SWDIO_OE,
  swd_target_port_if.master        be,
  output logic                     line_reset,
  output logic                     protocol_err
);
  localparam int LRW = $clog2(LINE_RESET_BITS + 1);

  logic rise, bit_s;

  swd_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i   (CLK),
    .rst_i   (PORESET),
    .swclk_i (SWCLK),
    .swdio_i (SWDIO_I),
    .rise_o  (rise),
    .swdio_o (bit_s)
  );

  swd_state_e  state_q;
  logic [5:0]  cnt_q;
  logic [3:0]  req_sh_q;
  logic [31:0] data_q;
  logic        rpar_q;
  ack_t        ack_q;
  logic        dio_o_q, dio_oe_q;
  logic        req_valid_q, req_apndp_q, req_rnw_q;
  logic [1:0]  req_addr_q;
  logic        wr_valid_q, wr_perr_q;
  logic [31:0] wr_data_q;
  logic        line_reset_q, proto_err_q;
  logic [LRW-1:0] lr_cnt_q, lr_cnt_d;
  logic        lr_hit;
  ack_t        ack_sel;

  // Run length of sampled 1s; lr_hit fires only on the step that reaches
  // the threshold, so a held-high line gives a single pulse.
  always_comb begin
    lr_cnt_d = lr_cnt_q;
    lr_hit   = 1'b0;
    if (rise) begin
      if (!bit_s) begin
        lr_cnt_d = '0;
      end else if (lr_cnt_q != LRW'(LINE_RESET_BITS)) begin
        lr_cnt_d = lr_cnt_q + LRW'(1);
        lr_hit   = (lr_cnt_q == LRW'(LINE_RESET_BITS - 1));
      end
    end
  end

  // A missing response answers WAIT; a malformed one answers FAULT.
  always_comb begin
    ack_sel = be.rsp_ack;
    if (!be.rsp_valid)             ack_sel = ACK_WAIT;
    else if (!$onehot(be.rsp_ack)) ack_sel = ACK_FAULT;
  end

  always_ff @(posedge CLK) begin
    if (PORESET) begin
      state_q      <= ST_LOCKOUT;
      cnt_q        <= '0;
      req_sh_q     <= '0;
      data_q       <= '0;
      rpar_q       <= 1'b0;
      ack_q        <= '0;
      dio_o_q      <= 1'b0;
      dio_oe_q     <= 1'b0;
      req_valid_q  <= 1'b0;
      req_apndp_q  <= 1'b0;
      req_rnw_q    <= 1'b0;
      req_addr_q   <= '0;
      wr_valid_q   <= 1'b0;
      wr_perr_q    <= 1'b0;
      wr_data_q    <= '0;
      line_reset_q <= 1'b0;
      proto_err_q  <= 1'b0;
      lr_cnt_q     <= '0;
    end else begin
      req_valid_q  <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_perr_q    <= 1'b0;
      line_reset_q <= 1'b0;
      proto_err_q  <= 1'b0;
      lr_cnt_q     <= lr_cnt_d;
      if (rise) begin
        if (lr_hit) begin
          // Line reset beats every state, including a coincident REQ error.
          line_reset_q <= 1'b1;
          dio_oe_q     <= 1'b0;
          dio_o_q      <= 1'b0;
          state_q      <= ST_LRST;
        end else begin
          case (state_q)
            ST_LOCKOUT: ;
            ST_LRST: if (!bit_s) state_q <= ST_IDLE;
            ST_IDLE: if (bit_s) begin
              state_q <= ST_REQ;
              cnt_q   <= '0;
            end
            ST_REQ: begin
              cnt_q <= cnt_q + 6'd1;
              if (cnt_q < 6'(REQ_PAR)) begin
                req_sh_q <= {bit_s, req_sh_q[3:1]};
              end else if ((cnt_q == 6'(REQ_PAR)  && bit_s != even_parity({28'd0, req_sh_q})) ||
                           (cnt_q == 6'(REQ_STOP) && bit_s) ||
                           (cnt_q == 6'(REQ_PARK) && !bit_s)) begin
                proto_err_q <= 1'b1;
                state_q     <= ST_LOCKOUT;
              end else if (cnt_q == 6'(REQ_PARK)) begin
                req_valid_q <= 1'b1;
                req_apndp_q <= req_sh_q[REQ_APNDP];
                req_rnw_q   <= req_sh_q[REQ_RNW];
                req_addr_q  <= {req_sh_q[REQ_A3], req_sh_q[REQ_A2]};
                state_q     <= ST_TRN1;
              end
            end
            ST_TRN1: begin
              if (be.rsp_valid) begin
                data_q <= be.rsp_rdata;
                rpar_q <= even_parity(be.rsp_rdata);
              end
              ack_q    <= ack_sel;
              dio_oe_q <= 1'b1;
              dio_o_q  <= ack_sel[0];
              cnt_q    <= '0;
              state_q  <= ST_ACK;
            end
            ST_ACK: begin
              cnt_q <= cnt_q + 6'd1;
              if (cnt_q == 6'd0) begin
                dio_o_q <= ack_q[1];
              end else if (cnt_q == 6'd1) begin
                dio_o_q <= ack_q[2];
              end else if (ack_q == ACK_OK && req_rnw_q) begin
                // Rise that ends the ACK[2] slot launches rdata[0].
                dio_o_q <= data_q[0];
                data_q  <= {1'b0, data_q[31:1]};
                cnt_q   <= '0;
                state_q <= ST_RDATA;
              end else begin
                state_q <= ST_TRN2;
              end
            end
            ST_RDATA: begin
              cnt_q <= cnt_q + 6'd1;
              if (cnt_q < 6'd31) begin
                dio_o_q <= data_q[0];
                data_q  <= {1'b0, data_q[31:1]};
              end else if (cnt_q == 6'd31) begin
                dio_o_q <= rpar_q;
              end else begin
                dio_oe_q <= 1'b0;
                dio_o_q  <= 1'b0;
                state_q  <= ST_IDLE;
              end
            end
            ST_TRN2: begin
              dio_oe_q <= 1'b0;
              dio_o_q  <= 1'b0;
              cnt_q    <= '0;
              state_q  <= (ack_q == ACK_OK && !req_rnw_q) ? ST_WDATA : ST_IDLE;
            end
            ST_WDATA: begin
              cnt_q <= cnt_q + 6'd1;
              if (cnt_q < 6'd32) begin
                data_q <= {bit_s, data_q[31:1]};
              end else begin
                if (bit_s == even_parity(data_q)) begin
                  wr_data_q  <= data_q;
                  wr_valid_q <= 1'b1;
                end else begin
                  wr_perr_q <= 1'b1;
                end
                state_q <= ST_IDLE;
              end
            end
            default: state_q <= ST_LOCKOUT;
          endcase
        end
      end
    end
  end

  assign SWDIO_O          = dio_o_q;
  assign SWDIO_OE         = dio_oe_q;
  assign be.req_valid     = req_valid_q;
  assign be.req_apndp     = req_apndp_q;
  assign be.req_rnw       = req_rnw_q;
  assign be.req_addr      = req_addr_q;
  assign be.wr_valid      = wr_valid_q;
  assign be.wr_data       = wr_data_q;
  assign be.wr_parity_err = wr_perr_q;
  assign line_reset       = line_reset_q;
  assign protocol_err     = proto_err_q;

endmodule
